fp_mul_pipe: RTL and testbench

- Parametrised, fully pipelined IEEE-754-style floating-point multiplier. Successor to the fixed single-precision multiplier.
- Adds generic exponent/mantissa widths, a valid/ready handshake with backpressure, and round-to-nearest-even.
- Handles zero, infinity and NaN classes explicitly and reports four exception flags per result.
- Sits in the arithmetic datapath between operand staging and the result writeback buffer.

---
 rtl/fp_mul_pkg.sv | 36 +++
 rtl/fp_mul_pipe_if.sv | 30 +++
 rtl/fp_mul_pipe_unpack.sv | 35 +++
 rtl/fp_mul_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types and constants for the fp_mul_pipe slice.
//   fp_class_e       operand class (zero, normal, infinity, NaN)
//   FLG_*            bit positions inside the 4-bit exception flag vector
//   fp_bias()        exponent bias for a given exponent width
//   fp_qnan()        canonical quiet NaN pattern, LSB-aligned in 128 bits
package fp_mul_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    localparam int unsigned FLG_INV = 3;
    localparam int unsigned FLG_OVF = 2;
    localparam int unsigned FLG_UNF = 1;
    localparam int unsigned FLG_INX = 0;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (2 ** (exp_w - 1)) - 1;
    endfunction

    // {0, all-ones exponent, fraction MSB set}; callers truncate to their width.
    function automatic logic [127:0] fp_qnan(input int unsigned exp_w,
                                             input int unsigned man_w);
        logic [127:0] r;
        r = '0;
        for (int unsigned i = 0; i < exp_w; i++) begin
            r[man_w + i] = 1'b1;
        end
        r[man_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if: operand/result handshake bundle for fp_mul_pipe.
//   in_valid/in_ready/a/b                 operand side
//   out_valid/out_ready/out_data/out_flags result side
//   master: operand producer + result consumer; slave: the multiplier.
interface fp_mul_pipe_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   out_flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

endinterface

// File: rtl/fp_mul_pipe_unpack.sv
// fp_unpack: combinational split of a packed {sign, exp, frac} operand and
// classification into zero / normal / infinity / NaN. Subnormals (exp == 0)
// are reported as zero.
//   i_op    packed operand
//   o_sign  sign bit
//   o_exp   biased exponent field
//   o_frac  stored fraction (hidden bit not included)
//   o_cls   operand class
module fp_unpack
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] i_op,
    output logic                 o_sign,
    output logic [EXP_W-1:0]     o_exp,
    output logic [MAN_W-1:0]     o_frac,
    output fp_class_e            o_cls
);

    assign o_sign = i_op[EXP_W+MAN_W];
    assign o_exp  = i_op[MAN_W +: EXP_W];
    assign o_frac = i_op[MAN_W-1:0];

    always_comb begin
        o_cls = CLS_NORM;
        if (o_exp == '0) begin
            o_cls = CLS_ZERO;
        end else if (o_exp == '1) begin
            o_cls = (o_frac == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 4-stage pipelined floating-point multiplier, round to nearest
// even, subnormals flushed to zero, canonical qNaN on invalid operations.
//   clk, reset      clock, asynchronous active-low reset
//   bus (slave)     in_valid/in_ready/a/b, out_valid/out_ready/out_data/out_flags
//                   out_flags = {invalid, overflow, underflow, inexact}
// Optional (FP_MUL_STICKY_FLAGS_EN defined):
//   clr_flags       clear accumulated flags (this cycle's handshake still lands)
//   sticky_flags    OR of out_flags over every accepted result
// Stages: S1 classify + exponent sum, S2 significand product,
//         S3 normalise + round, S4 special-case pack into output registers.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic        clk,
    input  logic        reset,
`ifdef FP_MUL_STICKY_FLAGS_EN
    input  logic        clr_flags,
    output logic [3:0]  sticky_flags,
`endif
    fp_mul_pipe_if.slave bus
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned SW = MAN_W + 1;
    localparam int unsigned PW = 2 * SW;

    localparam logic [W-1:0]  QNAN = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
    localparam logic [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);

    // Single advance enable: every stage moves together or holds together.
    logic w_adv;
    assign w_adv       = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    // ---------------- S1: unpack / classify ----------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    fp_class_e        w_ca, w_cb;
    logic [EW-1:0]    w_e1;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .i_op(bus.a), .o_sign(w_sa), .o_exp(w_ea), .o_frac(w_fa), .o_cls(w_ca)
    );

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .i_op(bus.b), .o_sign(w_sb), .o_exp(w_eb), .o_frac(w_fb), .o_cls(w_cb)
    );

    // Two's-complement exponent; the two extra bits hold the sign and the
    // carry so both overflow and "<= 0" can be read off directly later.
    assign w_e1 = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;

    logic            r_s1_valid, r_s1_sign;
    fp_class_e       r_s1_ca, r_s1_cb;
    logic [EW-1:0]   r_s1_e;
    logic [SW-1:0]   r_s1_ma, r_s1_mb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_ca    <= CLS_ZERO;
            r_s1_cb    <= CLS_ZERO;
            r_s1_e     <= '0;
            r_s1_ma    <= '0;
            r_s1_mb    <= '0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s1_sign  <= w_sa ^ w_sb;
            r_s1_ca    <= w_ca;
            r_s1_cb    <= w_cb;
            r_s1_e     <= w_e1;
            r_s1_ma    <= {1'b1, w_fa};
            r_s1_mb    <= {1'b1, w_fb};
        end
    end

    // ---------------- S2: significand product ----------------
    logic            r_s2_valid, r_s2_sign;
    fp_class_e       r_s2_ca, r_s2_cb;
    logic [EW-1:0]   r_s2_e;
    logic [PW-1:0]   r_s2_prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_ca    <= CLS_ZERO;
            r_s2_cb    <= CLS_ZERO;
            r_s2_e     <= '0;
            r_s2_prod  <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_ca    <= r_s1_ca;
            r_s2_cb    <= r_s1_cb;
            r_s2_e     <= r_s1_e;
            r_s2_prod  <= PW'(r_s1_ma) * PW'(r_s1_mb);
        end
    end

    // ---------------- S3: normalise and round ----------------
    // w_norm drops the leading one, so its top MAN_W bits are the fraction
    // whichever way the product was aligned.
    logic [PW-2:0]    w_norm;
    logic [EW-1:0]    w_e3a, w_e3;
    logic [MAN_W-1:0] w_frac_t, w_frac3;
    logic             w_g, w_r, w_s, w_up;
    logic [SW:0]      w_sig;

    always_comb begin
        if (r_s2_prod[PW-1]) begin
            w_norm = r_s2_prod[PW-2:0];
            w_e3a  = r_s2_e + EW'(1);
        end else begin
            w_norm = {r_s2_prod[PW-3:0], 1'b0};
            w_e3a  = r_s2_e;
        end
        w_frac_t = w_norm[PW-2 -: MAN_W];
        w_g      = w_norm[PW-2-MAN_W];
        w_r      = w_norm[PW-3-MAN_W];
        w_s      = |w_norm[PW-4-MAN_W:0];
        w_up     = w_g & (w_r | w_s | w_frac_t[0]);
        w_sig    = {2'b01, w_frac_t} + (SW+1)'(w_up);
        if (w_sig[SW]) begin
            w_frac3 = w_sig[MAN_W:1];
            w_e3    = w_e3a + EW'(1);
        end else begin
            w_frac3 = w_sig[MAN_W-1:0];
            w_e3    = w_e3a;
        end
    end

    logic             r_s3_valid, r_s3_sign, r_s3_inx;
    fp_class_e        r_s3_ca, r_s3_cb;
    logic [EW-1:0]    r_s3_e;
    logic [MAN_W-1:0] r_s3_frac;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s3_valid <= 1'b0;
            r_s3_sign  <= 1'b0;
            r_s3_inx   <= 1'b0;
            r_s3_ca    <= CLS_ZERO;
            r_s3_cb    <= CLS_ZERO;
            r_s3_e     <= '0;
            r_s3_frac  <= '0;
        end else if (w_adv) begin
            r_s3_valid <= r_s2_valid;
            r_s3_sign  <= r_s2_sign;
            r_s3_inx   <= w_g | w_r | w_s;
            r_s3_ca    <= r_s2_ca;
            r_s3_cb    <= r_s2_cb;
            r_s3_e     <= w_e3;
            r_s3_frac  <= w_frac3;
        end
    end

    // ---------------- S4: special-case pack ----------------
    logic [W-1:0] w_data4;
    logic [3:0]   w_flags4;
    logic         w_any_nan, w_any_inf, w_any_zero;

    always_comb begin
        w_any_nan  = (r_s3_ca == CLS_NAN)  || (r_s3_cb == CLS_NAN);
        w_any_inf  = (r_s3_ca == CLS_INF)  || (r_s3_cb == CLS_INF);
        w_any_zero = (r_s3_ca == CLS_ZERO) || (r_s3_cb == CLS_ZERO);
        w_data4    = '0;
        w_flags4   = '0;
        if (w_any_nan || (w_any_inf && w_any_zero)) begin
            w_data4           = QNAN;
            w_flags4[FLG_INV] = 1'b1;
        end else if (w_any_inf) begin
            w_data4 = {r_s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_any_zero) begin
            w_data4 = {r_s3_sign, {(W-1){1'b0}}};
        end else if (!r_s3_e[EW-1] && (r_s3_e >= EMAX)) begin
            w_data4           = {r_s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags4[FLG_OVF] = 1'b1;
            w_flags4[FLG_INX] = 1'b1;
        end else if (r_s3_e[EW-1] || (r_s3_e == '0)) begin
            w_data4           = {r_s3_sign, {(W-1){1'b0}}};
            w_flags4[FLG_UNF] = 1'b1;
            w_flags4[FLG_INX] = 1'b1;
        end else begin
            w_data4           = {r_s3_sign, r_s3_e[EXP_W-1:0], r_s3_frac};
            w_flags4[FLG_INX] = r_s3_inx;
        end
    end

    logic         r_s4_valid;
    logic [W-1:0] r_s4_data;
    logic [3:0]   r_s4_flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s4_valid <= 1'b0;
            r_s4_data  <= '0;
            r_s4_flags <= '0;
        end else if (w_adv) begin
            r_s4_valid <= r_s3_valid;
            r_s4_data  <= w_data4;
            r_s4_flags <= w_flags4;
        end
    end

    assign bus.out_valid = r_s4_valid;
    assign bus.out_data  = r_s4_data;
    assign bus.out_flags = r_s4_flags;

`ifdef FP_MUL_STICKY_FLAGS_EN
    // Clear and a same-cycle handshake combine so that result's flags survive.
    logic [3:0] r_sticky;
    logic       w_hs;

    assign w_hs = r_s4_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (clr_flags ? 4'b0000 : r_sticky) | (w_hs ? r_s4_flags : 4'b0000);
        end
    end

    assign sticky_flags = r_sticky;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: self-checking bench for fp_mul_pipe (EXP_W=8, MAN_W=23).
// Expected results come from an arithmetic reference model evaluated when
// each operand pair is accepted; one negedge process compares every result
// handshake, output stability under stall, and reset behaviour.
module tb_fp_mul_pipe;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus_if ();

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic       clr_flags = 1'b0;
    logic [3:0] sticky_flags;
    logic [3:0] m_sticky  = 4'b0000;
`endif

    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef FP_MUL_STICKY_FLAGS_EN
        .clr_flags    (clr_flags),
        .sticky_flags (sticky_flags),
`endif
        .bus          (bus_if)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  f;
        bit          has_lit;
        logic [31:0] ld;
        logic [3:0]  lf;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          lit_en   = 1'b0;
    logic [31:0] lit_d    = '0;
    logic [3:0]  lit_f    = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: exact integer product, then round-to-nearest-even on
    // the discarded remainder, then the special-case priority list.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic [3:0] f);
        int              ea, eb, e, sh;
        bit              s, za, zb, ia, ib, na, nb, up;
        longint unsigned ma, mb, p, kept, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (za && ib) || (zb && ia)) begin
            d = 32'h7FC00000; f = 4'b1000; return;
        end
        if (ia || ib) begin
            d = {s, 8'hFF, 23'h0}; f = 4'b0000; return;
        end
        if (za || zb) begin
            d = {s, 31'h0}; f = 4'b0000; return;
        end
        ma = 64'(a[22:0]) + (64'd1 << 23);
        mb = 64'(b[22:0]) + (64'd1 << 23);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24; e = e + 1;
        end else begin
            sh = 23;
        end
        kept = p >> sh;
        rem  = p & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        up   = (rem > half) || ((rem == half) && kept[0]);
        kept = kept + 64'(up);
        if (kept == (64'd1 << 24)) begin
            kept = kept >> 1; e = e + 1;
        end
        if (e >= 255) begin
            d = {s, 8'hFF, 23'h0}; f = 4'b0101;
        end else if (e <= 0) begin
            d = {s, 31'h0}; f = 4'b0011;
        end else begin
            d = {s, e[7:0], kept[22:0]}; f = {3'b000, rem != 0};
        end
    endfunction

    // ---------------- compare process ----------------
    bit          prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic [3:0]  prev_f;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] md;
        logic [3:0]  mf;
        if (!reset) begin
            sb.delete();
            prev_stall = 1'b0;
            chk("reset_out_valid", 64'(bus_if.out_valid), 64'd0);
            chk("reset_out_data",  64'(bus_if.out_data),  64'd0);
            chk("reset_out_flags", 64'(bus_if.out_flags), 64'd0);
`ifdef FP_MUL_STICKY_FLAGS_EN
            m_sticky = 4'b0000;
            chk("reset_sticky", 64'(sticky_flags), 64'd0);
`endif
        end else begin
            if (prev_stall) begin
                chk("stall_out_valid", 64'(bus_if.out_valid), 64'd1);
                chk("stall_out_data",  64'(bus_if.out_data),  64'(prev_d));
                chk("stall_out_flags", 64'(bus_if.out_flags), 64'(prev_f));
            end
`ifdef FP_MUL_STICKY_FLAGS_EN
            chk("sticky_flags", 64'(sticky_flags), 64'(m_sticky));
            if (clr_flags) m_sticky = 4'b0000;
            if (bus_if.out_valid && bus_if.out_ready) m_sticky = m_sticky | bus_if.out_flags;
`endif
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 64'(bus_if.out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data",  64'(bus_if.out_data),  64'(e.d));
                    chk("out_flags", 64'(bus_if.out_flags), 64'(e.f));
                    if (e.has_lit) begin
                        chk("literal_data",  64'(bus_if.out_data),  64'(e.ld));
                        chk("literal_flags", 64'(bus_if.out_flags), 64'(e.lf));
                    end
                end
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
                model(bus_if.a, bus_if.b, md, mf);
                e.d = md; e.f = mf; e.has_lit = lit_en; e.ld = lit_d; e.lf = lit_f;
                sb.push_back(e);
            end
            prev_stall = bus_if.out_valid && !bus_if.out_ready;
            prev_d     = bus_if.out_data;
            prev_f     = bus_if.out_flags;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input bit hl,
                        input logic [31:0] ld, input logic [3:0] lf);
        int unsigned budget;
        budget          = 0;
        bus_if.in_valid = 1'b1;
        bus_if.a        = xa;
        bus_if.b        = xb;
        lit_en          = hl;
        lit_d           = ld;
        lit_f           = lf;
        @(negedge clk);
        while (!bus_if.in_ready && budget < 200) begin
            budget++;
            @(negedge clk);
        end
        if (!bus_if.in_ready) chk("accept_timeout", 64'(bus_if.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        lit_en          = 1'b0;
    endtask

    task automatic drain();
        int unsigned budget;
        budget = 0;
        while (sb.size() != 0 && budget < 500) begin
            budget++;
            @(negedge clk);
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        int unsigned k;
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0) begin
            r[30:23] = 8'h00;
        end else if (k == 1) begin
            r[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 0) r[22:0] = '0;
        end else if (k < 6) begin
            r[30:23] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(190, 254))
                                                   : 8'($urandom_range(1, 64));
        end else begin
            r[30:23] = 8'($urandom_range(100, 154));
        end
        if (k >= 14) r[11:0] = '0;
        return r;
    endfunction

    logic [31:0] va[8], vb[8], vd[8];
    logic [3:0]  vf[8];
    bit          rand_done = 1'b0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] md;
        logic [3:0]  mf;
        int          cnt;

        va[0] = 32'h3FC00000; vb[0] = 32'h40000000; vd[0] = 32'h40400000; vf[0] = 4'b0000;
        va[1] = 32'h3F800001; vb[1] = 32'h3FC00000; vd[1] = 32'h3FC00002; vf[1] = 4'b0001;
        va[2] = 32'h7F7FFFFF; vb[2] = 32'h40000000; vd[2] = 32'h7F800000; vf[2] = 4'b0101;
        va[3] = 32'hFF800000; vb[3] = 32'h3F800000; vd[3] = 32'hFF800000; vf[3] = 4'b0000;
        va[4] = 32'h00000000; vb[4] = 32'hFF800000; vd[4] = 32'h7FC00000; vf[4] = 4'b1000;
        va[5] = 32'h7F800001; vb[5] = 32'h3F800000; vd[5] = 32'h7FC00000; vf[5] = 4'b1000;
        va[6] = 32'h00800000; vb[6] = 32'h3F000000; vd[6] = 32'h00000000; vf[6] = 4'b0011;
        va[7] = 32'h80000000; vb[7] = 32'h3F800000; vd[7] = 32'h80000000; vf[7] = 4'b0000;

        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // The model must reproduce the hand-derived vectors.
        for (int i = 0; i < 8; i++) begin
            model(va[i], vb[i], md, mf);
            chk("model_pin_data",  64'(md), 64'(vd[i]));
            chk("model_pin_flags", 64'(mf), 64'(vf[i]));
        end

        // Isolated op: result must appear in the 4th cycle after acceptance.
        @(posedge clk);
        #1;
        send(va[0], vb[0], 1'b1, vd[0], vf[0]);
        cnt = 1;
        while (!bus_if.out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("latency_cycles", 64'(cnt), 64'd4);
        drain();

        for (int i = 1; i < 8; i++) send(va[i], vb[i], 1'b1, vd[i], vf[i]);
        drain();

        // Back-to-back stream with a 6-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_op(), rand_op(), 1'b0, '0, '0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus_if.out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 bus_if.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with operations in flight: nothing stale may come out after.
        for (int i = 0; i < 3; i++) send(rand_op(), rand_op(), 1'b0, '0, '0);
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_idle", 64'(bus_if.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Random operands, random gaps, random backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rand_op(), rand_op(), 1'b0, '0, '0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 bus_if.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus_if.out_ready = 1'b1;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
